core_fetch_miss_ctrl: RTL and testbench
=======================================

Name: core_fetch_miss_ctrl

Overview:
Parametrised miss/skid engine for the instruction fetch F2 stage. It takes one miss or cache-op request at a time and handles the full sequence:
- cached line refill (burst) with round-robin victim selection, or per-slot uncached fetch, or a cache-op invalidate;
- tag/data SRAM writes;
- returns the missed FETCH_WIDTH-wide instruction packet for the fetch skid buffer.

It generalises the 2-wide fetch miss FSM to N-wide fetch, arbitrary line length and way count, and adds flush-kill semantics.

Parameters:
FETCH_WIDTH, 2, instructions per fetch packet (power of 2, ≤ LINE_WORDS)
LINE_WORDS, 4, 32-bit words per cache line (power of 2, ≥ 1)
WAY_CNT, 2, associativity (power of 2, ≥ 1)
TAG_LEN, 20, physical tag bits
IDX_LEN, 12, index+offset bits; tag = paddr[TAG_LEN+IDX_LEN-1:IDX_LEN]

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush_i  in  1  pipeline flush; kills pending response
miss_valid_i  in  1  request valid
miss_ready_o  out  1  engine idle, can accept
miss_uncache_i  in  1  uncached fetch
miss_paddr_i  in  32  physical PC (packet-aligned) or cache-op address
miss_mask_i  in  FETCH_WIDTH  valid slots in packet
cacheop_valid_i  in  1  request is a cache op
cacheop_i  in  2  0/1 index-invalidate, 2 hit-invalidate, 3 no-op
hit_way_i  in  WAY_CNT  F2 hit vector (used by op 2)
bus_busy_i  in  1  shared bus owned by another master
bus_req_valid_o  out  1  read request
bus_req_addr_o  out  32  start address
bus_req_len_o  out  8  beats-1
bus_req_cached_o  out  1  1 = line burst
bus_req_ready_i  in  1  request accepted
bus_resp_valid_i  in  1  read beat valid
bus_resp_data_i  in  32  read beat data
bus_resp_last_i  in  1  final beat
sram_tag_we_o  out  WAY_CNT  tag write enables
sram_data_we_o  out  WAY_CNT  data word write enables
sram_waddr_o  out  32  write address (word-granular)
sram_wtag_o  out  TAG_LEN+1  {valid, tag}
sram_wdata_o  out  32  data word
done_o  out  1  one-cycle response pulse
done_valid_o  out  FETCH_WIDTH  returned slot valids ('0 for cache ops)
done_data_o  out  FETCH_WIDTH*32  returned instructions, slot 0 in LSBs

Behaviour:
- Reset: state IDLE. All outputs 0 except miss_ready_o=1. Victim counter 0, kill_q 0. Reset mid-operation abandons everything; bus reset is shared.
- Acceptance: accept when miss_valid_i & miss_ready_o & !flush_i. Latch paddr, mask, uncache, cacheop.
- FSM states: IDLE, WAITBUS, CACOP, RFADDR, RFDATA, PTADDR, PTDATA, RECOVER.
- IDLE → on accept:
  - CACOP if cacheop_valid_i;
  - else WAITBUS if bus_busy_i;
  - else PTADDR if uncache;
  - else RFADDR.
- WAITBUS: hold until !bus_busy_i, then go to PTADDR or RFADDR.
- CACOP (1 cycle):
  - ops 0/1: tag write valid=0 at the index, way = paddr[$clog2(WAY_CNT)-1:0];
  - op 2: tag write to the ways set in hit_way_i (none if 0);
  - op 3: no write.
  - Then go to RECOVER.
- RFADDR:
  - bus_req_valid_o=1, addr = line-aligned paddr, len = LINE_WORDS-1, cached=1.
  - Hold until bus_req_ready_i, then go to RFDATA.
- RFDATA: per beat k (beat counter wraps at LINE_WORDS):
  - data_we on victim way, word address = line base + 4k.
  - Beat 0 also writes tag valid=0. The last beat writes tag valid=1 with the latched tag; for LINE_WORDS=1 only valid=1 is written.
  - Beats whose word index falls inside the missed packet are captured into the slot registers.
  - On bus_resp_last_i: go to RECOVER and advance the victim counter (mod WAY_CNT).
- PTADDR/PTDATA:
  - One single-beat request (len 0, cached 0) per set mask bit, ascending slot order.
  - Each returned beat is captured into its slot.
  - After the highest valid slot: go to RECOVER.
  - Mask 0: go directly to RECOVER.
- RECOVER (1 cycle):
  - done_o = !kill_q; done_valid_o = latched mask (0 for cacheop); done_data_o = captured slots.
  - This cycle also lets the SRAM read port replay.
  - Then go to IDLE; clear kill_q.
- Flush:
  - flush_i while not IDLE sets kill_q.
  - The operation always runs to completion: no request withdrawal, all beats drained, SRAM writes still performed. Only done_o is suppressed.
  - flush_i in IDLE has no effect and blocks acceptance that cycle.
- Latency (cached miss, zero-wait bus, no busy):
  - accept at T; RFADDR at T+1; beats at T+2..T+1+LINE_WORDS; RECOVER / done_o at T+2+LINE_WORDS.
- Simultaneous events:
  - bus_resp_valid_i outside RFDATA/PTDATA is ignored.
  - bus_busy_i after WAITBUS exit is ignored.

Decomposition:
- Shared package (fetch pkg): FSM state enum, cacheop encodings (CACOP_IDX_INV0/1, CACOP_HIT_INV, CACOP_NOP), the tag struct {valid, tag}, and address-slicing functions (tag, index, word offset).
- One natural sub-module: core_fetch_victim_rr, a round-robin victim counter with advance enable and a one-hot way output.

Test Plan:
- Cached miss, paddr=0x1C00_0008, mask=2'b11, LINE_WORDS=4, beats 0xA0..0xA3 → req addr 0x1C00_0000 len 3; tag writes valid=0 then valid=1 on way 0; done_o at T+6 with data {0xA3,0xA2}.
- Uncached, mask=2'b10, paddr=0x1000 → exactly one request, addr 0x1004 len 0 cached 0; done_valid_o=2'b10; no SRAM writes.
- bus_busy_i high 3 cycles after accept → bus_req_valid_o stays 0 until 1 cycle after busy drops; the fill then completes normally.
- flush_i asserted during beat 1 of a refill → all 4 data writes plus tag valid=1 still occur; done_o stays 0; miss_ready_o returns to 1.
- Cacheop 2 with hit_way_i=2'b10 → sram_tag_we_o=2'b10, wtag valid=0; done_o=1 with done_valid_o=0. Cacheop 1 with paddr[0]=0 → sram_tag_we_o=2'b01.
- Two back-to-back cached misses to the same index → victim ways 0 then 1; a third miss wraps to way 0.

Source files
------------

// File: rtl/core_fetch_pkg.sv
// Shared types and address helpers for the instruction-fetch miss engine.
package core_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAITBUS,
        ST_CACOP,
        ST_RFADDR,
        ST_RFDATA,
        ST_PTADDR,
        ST_PTDATA,
        ST_RECOVER
    } fetch_state_e;

    localparam logic [1:0] CACOP_IDX_INV0 = 2'd0;
    localparam logic [1:0] CACOP_IDX_INV1 = 2'd1;
    localparam logic [1:0] CACOP_HIT_INV  = 2'd2;
    localparam logic [1:0] CACOP_NOP      = 2'd3;

    // Tag field is held at full address width; users slice it down to TAG_LEN.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
    } fetch_tag_t;

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx_len);
        return a >> idx_len;
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int idx_len,
                                               input int line_words);
        return (a & ((32'd1 << idx_len) - 32'd1)) >> ($clog2(line_words) + 2);
    endfunction

    function automatic int word_off(input logic [31:0] a, input int line_words);
        return int'((a >> 2) & 32'(line_words - 1));
    endfunction

endpackage

// File: rtl/core_fetch_victim_rr.sv
// Round-robin victim way selector; advances once per completed line refill.
module core_fetch_victim_rr #(
    parameter int WAY_CNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv_i,
    output logic [WAY_CNT-1:0] way_o
);
    localparam int WAY_W = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

    logic [WAY_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == WAY_W'(WAY_CNT - 1)) ? '0 : cnt_q + WAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign way_o = WAY_CNT'(1) << cnt_q;
endmodule

// File: rtl/core_fetch_miss_ctrl.sv
// F2 miss/skid engine: line refill, uncached per-slot fetch or cache-op invalidate,
// then a one-cycle response of the missed packet. Flush only suppresses done_o.
module core_fetch_miss_ctrl
    import core_fetch_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int LINE_WORDS  = 4,
    parameter int WAY_CNT     = 2,
    parameter int TAG_LEN     = 20,
    parameter int IDX_LEN     = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      miss_valid_i,
    output logic                      miss_ready_o,
    input  logic                      miss_uncache_i,
    input  logic [31:0]               miss_paddr_i,
    input  logic [FETCH_WIDTH-1:0]    miss_mask_i,
    input  logic                      cacheop_valid_i,
    input  logic [1:0]                cacheop_i,
    input  logic [WAY_CNT-1:0]        hit_way_i,
    input  logic                      bus_busy_i,
    output logic                      bus_req_valid_o,
    output logic [31:0]               bus_req_addr_o,
    output logic [7:0]                bus_req_len_o,
    output logic                      bus_req_cached_o,
    input  logic                      bus_req_ready_i,
    input  logic                      bus_resp_valid_i,
    input  logic [31:0]               bus_resp_data_i,
    input  logic                      bus_resp_last_i,
    output logic [WAY_CNT-1:0]        sram_tag_we_o,
    output logic [WAY_CNT-1:0]        sram_data_we_o,
    output logic [31:0]               sram_waddr_o,
    output logic [TAG_LEN:0]          sram_wtag_o,
    output logic [31:0]               sram_wdata_o,
    output logic                      done_o,
    output logic [FETCH_WIDTH-1:0]    done_valid_o,
    output logic [FETCH_WIDTH*32-1:0] done_data_o,
    output fetch_state_e              dbg_state_o
);
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int WAY_W  = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam logic [31:0] LINE_OFS_MASK = 32'(LINE_WORDS * 4 - 1);

    fetch_state_e                 state_q, state_d;
    logic [31:0]                  paddr_q, paddr_d;
    logic [FETCH_WIDTH-1:0]       mask_q, mask_d, pend_q, pend_d;
    logic                         uncache_q, uncache_d, cacheop_q, cacheop_d, kill_q, kill_d;
    logic [1:0]                   op_q, op_d;
    logic [WAY_CNT-1:0]           hit_q, hit_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [SLOT_W-1:0]            slot_q, slot_d, first_slot;
    logic [FETCH_WIDTH-1:0][31:0] slots_q, slots_d;

    logic               victim_adv;
    logic [WAY_CNT-1:0] victim_oh;
    logic [31:0]        line_base;
    logic [WAY_W-1:0]   way_sel;
    fetch_tag_t         wtag_s;
    int                 pkt_word;
    logic               unused_tag_bits;

    core_fetch_victim_rr #(.WAY_CNT(WAY_CNT)) u_victim (
        .clk   (clk),
        .rst   (rst),
        .adv_i (victim_adv),
        .way_o (victim_oh)
    );

    assign line_base       = paddr_q & ~LINE_OFS_MASK;
    assign way_sel         = WAY_W'(paddr_q & 32'(WAY_CNT - 1));
    assign pkt_word        = word_off(paddr_q, LINE_WORDS) & ~(FETCH_WIDTH - 1);
    assign unused_tag_bits = ^wtag_s.tag[31:TAG_LEN];
    assign dbg_state_o     = state_q;

    always_comb begin
        first_slot = '0;
        for (int s = FETCH_WIDTH - 1; s >= 0; s--) begin
            if (pend_q[s]) first_slot = SLOT_W'(s);
        end
    end

    always_comb begin
        state_d = state_q;   paddr_d = paddr_q;     mask_d = mask_q;  pend_d = pend_q;
        uncache_d = uncache_q; cacheop_d = cacheop_q; op_d = op_q;    hit_d = hit_q;
        kill_d = kill_q;     beat_d = beat_q;       slot_d = slot_q;  slots_d = slots_q;
        victim_adv = 1'b0;
        miss_ready_o = 1'b0;
        bus_req_valid_o = 1'b0; bus_req_addr_o = '0; bus_req_len_o = '0; bus_req_cached_o = 1'b0;
        sram_tag_we_o = '0; sram_data_we_o = '0; sram_waddr_o = '0; sram_wdata_o = '0;
        wtag_s.valid = 1'b0;
        wtag_s.tag = addr_tag(paddr_q, IDX_LEN);
        done_o = 1'b0; done_valid_o = '0; done_data_o = '0;

        if (flush_i && state_q != ST_IDLE) kill_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i && !flush_i) begin
                    paddr_d = miss_paddr_i;  mask_d = miss_mask_i;  pend_d = miss_mask_i;
                    uncache_d = miss_uncache_i; cacheop_d = cacheop_valid_i;
                    op_d = cacheop_i;        hit_d = hit_way_i;     slots_d = '0;
                    if (cacheop_valid_i)     state_d = ST_CACOP;
                    else if (bus_busy_i)     state_d = ST_WAITBUS;
                    else if (!miss_uncache_i) state_d = ST_RFADDR;
                    else state_d = (miss_mask_i == '0) ? ST_RECOVER : ST_PTADDR;
                end
            end
            ST_WAITBUS: begin
                if (!bus_busy_i) begin
                    if (!uncache_q) state_d = ST_RFADDR;
                    else state_d = (mask_q == '0) ? ST_RECOVER : ST_PTADDR;
                end
            end
            ST_CACOP: begin
                sram_waddr_o = line_base;
                case (op_q)
                    CACOP_IDX_INV0, CACOP_IDX_INV1: sram_tag_we_o = WAY_CNT'(1) << way_sel;
                    CACOP_HIT_INV:                  sram_tag_we_o = hit_q;
                    default:                        sram_tag_we_o = '0;
                endcase
                state_d = ST_RECOVER;
            end
            ST_RFADDR: begin
                bus_req_valid_o = 1'b1; bus_req_addr_o = line_base;
                bus_req_len_o = 8'(LINE_WORDS - 1); bus_req_cached_o = 1'b1;
                if (bus_req_ready_i) begin
                    state_d = ST_RFDATA;
                    beat_d  = '0;
                end
            end
            ST_RFDATA: begin
                sram_waddr_o = line_base | (32'(beat_q) << 2);
                sram_wdata_o = bus_resp_data_i;
                if (bus_resp_valid_i) begin
                    sram_data_we_o = victim_oh;
                    for (int s = 0; s < FETCH_WIDTH; s++) begin
                        if (int'(beat_q) == pkt_word + s) slots_d[s] = bus_resp_data_i;
                    end
                    beat_d = (beat_q == BEAT_W'(LINE_WORDS - 1)) ? '0 : beat_q + BEAT_W'(1);
                    // Tag goes invalid on the first beat so a partial line is never hit.
                    if (bus_resp_last_i) begin
                        sram_tag_we_o = victim_oh;
                        wtag_s.valid  = 1'b1;
                        victim_adv    = 1'b1;
                        state_d       = ST_RECOVER;
                    end else if (beat_q == '0) begin
                        sram_tag_we_o = victim_oh;
                    end
                end
            end
            ST_PTADDR: begin
                if (pend_q == '0) begin
                    state_d = ST_RECOVER;
                end else begin
                    bus_req_valid_o = 1'b1;
                    bus_req_addr_o  = paddr_q + (32'(first_slot) << 2);
                    if (bus_req_ready_i) begin
                        slot_d  = first_slot;
                        state_d = ST_PTDATA;
                    end
                end
            end
            ST_PTDATA: begin
                if (bus_resp_valid_i) begin
                    for (int s = 0; s < FETCH_WIDTH; s++) begin
                        if (SLOT_W'(s) == slot_q) begin
                            slots_d[s] = bus_resp_data_i;
                            pend_d[s]  = 1'b0;
                        end
                    end
                    state_d = (pend_d == '0) ? ST_RECOVER : ST_PTADDR;
                end
            end
            ST_RECOVER: begin
                done_o       = !kill_q;
                done_valid_o = cacheop_q ? '0 : mask_q;
                done_data_o  = slots_q;
                kill_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        sram_wtag_o = {wtag_s.valid, wtag_s.tag[TAG_LEN-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;  paddr_q <= '0;   mask_q <= '0;    pend_q <= '0;
            uncache_q <= 1'b0;   cacheop_q <= 1'b0; op_q <= '0;    hit_q <= '0;
            kill_q <= 1'b0;      beat_q <= '0;    slot_q <= '0;    slots_q <= '0;
        end else begin
            state_q <= state_d;  paddr_q <= paddr_d; mask_q <= mask_d; pend_q <= pend_d;
            uncache_q <= uncache_d; cacheop_q <= cacheop_d; op_q <= op_d; hit_q <= hit_d;
            kill_q <= kill_d;    beat_q <= beat_d;  slot_q <= slot_d;  slots_q <= slots_d;
        end
    end
endmodule

// File: tb/tb_core_fetch_miss_ctrl.sv
// Directed bench for core_fetch_miss_ctrl with the default 2-wide, 4-word, 2-way setup.
module tb_core_fetch_miss_ctrl;
    import core_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, miss_valid_i, miss_ready_o, miss_uncache_i;
    logic [31:0] miss_paddr_i;
    logic [1:0]  miss_mask_i;
    logic        cacheop_valid_i;
    logic [1:0]  cacheop_i;
    logic [1:0]  hit_way_i;
    logic        bus_busy_i, bus_req_valid_o, bus_req_cached_o, bus_req_ready_i;
    logic [31:0] bus_req_addr_o;
    logic [7:0]  bus_req_len_o;
    logic        bus_resp_valid_i, bus_resp_last_i;
    logic [31:0] bus_resp_data_i;
    logic [1:0]  sram_tag_we_o, sram_data_we_o;
    logic [31:0] sram_waddr_o, sram_wdata_o;
    logic [20:0] sram_wtag_o;
    logic        done_o;
    logic [1:0]  done_valid_o;
    logic [63:0] done_data_o;
    fetch_state_e dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    core_fetch_miss_ctrl #(
        .FETCH_WIDTH(2), .LINE_WORDS(4), .WAY_CNT(2), .TAG_LEN(20), .IDX_LEN(12)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_uncache_i(miss_uncache_i), .miss_paddr_i(miss_paddr_i), .miss_mask_i(miss_mask_i),
        .cacheop_valid_i(cacheop_valid_i), .cacheop_i(cacheop_i), .hit_way_i(hit_way_i),
        .bus_busy_i(bus_busy_i), .bus_req_valid_o(bus_req_valid_o), .bus_req_addr_o(bus_req_addr_o),
        .bus_req_len_o(bus_req_len_o), .bus_req_cached_o(bus_req_cached_o),
        .bus_req_ready_i(bus_req_ready_i), .bus_resp_valid_i(bus_resp_valid_i),
        .bus_resp_data_i(bus_resp_data_i), .bus_resp_last_i(bus_resp_last_i),
        .sram_tag_we_o(sram_tag_we_o), .sram_data_we_o(sram_data_we_o),
        .sram_waddr_o(sram_waddr_o), .sram_wtag_o(sram_wtag_o), .sram_wdata_o(sram_wdata_o),
        .done_o(done_o), .done_valid_o(done_valid_o), .done_data_o(done_data_o),
        .dbg_state_o(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 0; miss_valid_i = 0; miss_uncache_i = 0; miss_paddr_i = '0; miss_mask_i = '0;
        cacheop_valid_i = 0; cacheop_i = '0; hit_way_i = '0; bus_busy_i = 0;
        bus_req_ready_i = 0; bus_resp_valid_i = 0; bus_resp_data_i = '0; bus_resp_last_i = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
        #1;
        vec_cnt++; if (miss_ready_o !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got=%b exp=1", miss_ready_o); end
        vec_cnt++; if (bus_req_valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_req got=%b exp=0", bus_req_valid_o); end
        vec_cnt++; if (done_o !== 1'b0 || done_valid_o !== 2'b00) begin err_cnt++; $display("FAIL reset_done got=%b/%b exp=0/00", done_o, done_valid_o); end
        vec_cnt++; if (sram_tag_we_o !== 2'b00) begin err_cnt++; $display("FAIL reset_tag_we got=%b exp=00", sram_tag_we_o); end
        bus_resp_valid_i = 1; bus_resp_data_i = 32'hDEAD_BEEF; bus_resp_last_i = 1;
        #1;
        vec_cnt++; if (sram_data_we_o !== 2'b00) begin err_cnt++; $display("FAIL idle_resp_ignored got=%b exp=00", sram_data_we_o); end
        tick();
        bus_resp_valid_i = 0; bus_resp_last_i = 0;
        #1;
        vec_cnt++; if (miss_ready_o !== 1'b1) begin err_cnt++; $display("FAIL idle_resp_ready got=%b exp=1", miss_ready_o); end
    endtask

    task automatic test_cached_miss(input logic [31:0] paddr, input logic [1:0] mask,
                                    input logic [1:0] exp_way, input logic [31:0] d0,
                                    input int busy_cyc, input int flush_beat, input string name);
        logic [31:0] base;
        logic [19:0] tag;
        logic [63:0] exp_data;
        logic [1:0]  exp_tag_we;
        int          pkt;
        base = paddr & ~32'hF;
        tag  = paddr[31:12];
        pkt  = int'((paddr >> 2) & 32'h3) & ~1;
        for (int s = 0; s < 2; s++) exp_data[s*32 +: 32] = d0 + 32'(pkt + s);

        miss_valid_i = 1; miss_paddr_i = paddr; miss_mask_i = mask; miss_uncache_i = 0;
        cacheop_valid_i = 0; bus_busy_i = (busy_cyc > 0);
        #1;
        vec_cnt++; if (miss_ready_o !== 1'b1) begin err_cnt++; $display("FAIL %s accept_ready got=%b exp=1", name, miss_ready_o); end
        tick();
        miss_valid_i = 0;
        if (busy_cyc > 0) begin
            for (int i = 0; i < busy_cyc; i++) begin
                #1;
                vec_cnt++; if (bus_req_valid_o !== 1'b0) begin err_cnt++; $display("FAIL %s busy_hold%0d got=%b exp=0", name, i, bus_req_valid_o); end
                tick();
            end
            bus_busy_i = 0;
            #1;
            vec_cnt++; if (bus_req_valid_o !== 1'b0) begin err_cnt++; $display("FAIL %s busy_drop got=%b exp=0", name, bus_req_valid_o); end
            tick();
            bus_busy_i = 1;
        end
        bus_req_ready_i = 1;
        #1;
        vec_cnt++; if (bus_req_valid_o !== 1'b1) begin err_cnt++; $display("FAIL %s req_valid got=%b exp=1", name, bus_req_valid_o); end
        vec_cnt++; if (bus_req_addr_o !== base) begin err_cnt++; $display("FAIL %s req_addr got=%h exp=%h", name, bus_req_addr_o, base); end
        vec_cnt++; if (bus_req_len_o !== 8'd3 || bus_req_cached_o !== 1'b1) begin err_cnt++; $display("FAIL %s req_len_cached got=%0d/%b exp=3/1", name, bus_req_len_o, bus_req_cached_o); end
        tick();
        bus_req_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            bus_resp_valid_i = 1; bus_resp_data_i = d0 + 32'(k); bus_resp_last_i = (k == 3);
            flush_i = (k == flush_beat);
            #1;
            vec_cnt++; if (sram_data_we_o !== exp_way) begin err_cnt++; $display("FAIL %s data_we%0d got=%b exp=%b", name, k, sram_data_we_o, exp_way); end
            vec_cnt++; if (sram_waddr_o !== base + 32'(4 * k) || sram_wdata_o !== d0 + 32'(k)) begin err_cnt++; $display("FAIL %s wr%0d got=%h:%h exp=%h:%h", name, k, sram_waddr_o, sram_wdata_o, base + 32'(4 * k), d0 + 32'(k)); end
            exp_tag_we = (k == 0 || k == 3) ? exp_way : 2'b00;
            vec_cnt++; if (sram_tag_we_o !== exp_tag_we) begin err_cnt++; $display("FAIL %s tag_we%0d got=%b exp=%b", name, k, sram_tag_we_o, exp_tag_we); end
            if (k == 0 || k == 3) begin
                vec_cnt++; if (sram_wtag_o !== {(k == 3), tag}) begin err_cnt++; $display("FAIL %s wtag%0d got=%h exp=%h", name, k, sram_wtag_o, {(k == 3), tag}); end
            end
            tick();
        end
        bus_resp_valid_i = 0; bus_resp_last_i = 0; flush_i = 0; bus_busy_i = 0;
        #1;
        vec_cnt++; if (done_o !== (flush_beat < 0)) begin err_cnt++; $display("FAIL %s done got=%b exp=%b", name, done_o, (flush_beat < 0)); end
        if (flush_beat < 0) begin
            vec_cnt++; if (done_valid_o !== mask) begin err_cnt++; $display("FAIL %s done_valid got=%b exp=%b", name, done_valid_o, mask); end
            vec_cnt++; if (done_data_o !== exp_data) begin err_cnt++; $display("FAIL %s done_data got=%h exp=%h", name, done_data_o, exp_data); end
        end
        tick();
        vec_cnt++; if (miss_ready_o !== 1'b1 || done_o !== 1'b0) begin err_cnt++; $display("FAIL %s back_idle got=%b/%b exp=1/0", name, miss_ready_o, done_o); end
    endtask

    task automatic test_uncached();
        miss_valid_i = 1; miss_uncache_i = 1; miss_mask_i = 2'b10; miss_paddr_i = 32'h0000_1000;
        tick();
        miss_valid_i = 0; miss_uncache_i = 0;
        bus_req_ready_i = 1;
        #1;
        vec_cnt++; if (bus_req_valid_o !== 1'b1 || bus_req_addr_o !== 32'h0000_1004) begin err_cnt++; $display("FAIL unc_req got=%b:%h exp=1:00001004", bus_req_valid_o, bus_req_addr_o); end
        vec_cnt++; if (bus_req_len_o !== 8'd0 || bus_req_cached_o !== 1'b0) begin err_cnt++; $display("FAIL unc_len_cached got=%0d/%b exp=0/0", bus_req_len_o, bus_req_cached_o); end
        tick();
        bus_req_ready_i = 0;
        bus_resp_valid_i = 1; bus_resp_data_i = 32'h0000_00B1; bus_resp_last_i = 1;
        #1;
        vec_cnt++; if (bus_req_valid_o !== 1'b0) begin err_cnt++; $display("FAIL unc_one_req got=%b exp=0", bus_req_valid_o); end
        vec_cnt++; if (sram_tag_we_o !== 2'b00 || sram_data_we_o !== 2'b00) begin err_cnt++; $display("FAIL unc_no_sram got=%b/%b exp=00/00", sram_tag_we_o, sram_data_we_o); end
        tick();
        bus_resp_valid_i = 0; bus_resp_last_i = 0;
        #1;
        vec_cnt++; if (done_o !== 1'b1 || done_valid_o !== 2'b10) begin err_cnt++; $display("FAIL unc_done got=%b/%b exp=1/10", done_o, done_valid_o); end
        vec_cnt++; if (done_data_o !== 64'h0000_00B1_0000_0000) begin err_cnt++; $display("FAIL unc_data got=%h exp=000000b100000000", done_data_o); end
        vec_cnt++; if (bus_req_valid_o !== 1'b0) begin err_cnt++; $display("FAIL unc_no_extra_req got=%b exp=0", bus_req_valid_o); end
        tick();

        // Both slots: two single-beat requests in ascending order.
        miss_valid_i = 1; miss_uncache_i = 1; miss_mask_i = 2'b11; miss_paddr_i = 32'h0000_2008;
        tick();
        miss_valid_i = 0; miss_uncache_i = 0;
        for (int s = 0; s < 2; s++) begin
            bus_req_ready_i = 1;
            #1;
            vec_cnt++; if (bus_req_valid_o !== 1'b1 || bus_req_addr_o !== 32'h0000_2008 + 32'(4 * s)) begin err_cnt++; $display("FAIL unc2_req%0d got=%b:%h exp=1:%h", s, bus_req_valid_o, bus_req_addr_o, 32'h0000_2008 + 32'(4 * s)); end
            tick();
            bus_req_ready_i = 0;
            bus_resp_valid_i = 1; bus_resp_data_i = 32'hC0 + 32'(s); bus_resp_last_i = 1;
            tick();
            bus_resp_valid_i = 0; bus_resp_last_i = 0;
        end
        #1;
        vec_cnt++; if (done_o !== 1'b1 || done_valid_o !== 2'b11 || done_data_o !== 64'h0000_00C1_0000_00C0) begin err_cnt++; $display("FAIL unc2_done got=%b/%b/%h exp=1/11/000000c1000000c0", done_o, done_valid_o, done_data_o); end
        tick();

        // Empty mask goes straight to the response without touching the bus.
        miss_valid_i = 1; miss_uncache_i = 1; miss_mask_i = 2'b00; miss_paddr_i = 32'h0000_3000;
        tick();
        miss_valid_i = 0; miss_uncache_i = 0;
        #1;
        vec_cnt++; if (done_o !== 1'b1 || done_valid_o !== 2'b00 || bus_req_valid_o !== 1'b0) begin err_cnt++; $display("FAIL unc_mask0 got=%b/%b/%b exp=1/00/0", done_o, done_valid_o, bus_req_valid_o); end
        tick();
    endtask

    task automatic test_cacheop(input logic [1:0] op, input logic [31:0] paddr,
                                input logic [1:0] hit, input logic [1:0] exp_we, input string name);
        miss_valid_i = 1; cacheop_valid_i = 1; cacheop_i = op; hit_way_i = hit; miss_paddr_i = paddr;
        miss_mask_i = 2'b11;
        tick();
        miss_valid_i = 0; cacheop_valid_i = 0;
        #1;
        vec_cnt++; if (sram_tag_we_o !== exp_we) begin err_cnt++; $display("FAIL %s tag_we got=%b exp=%b", name, sram_tag_we_o, exp_we); end
        vec_cnt++; if (sram_wtag_o[20] !== 1'b0 || sram_data_we_o !== 2'b00) begin err_cnt++; $display("FAIL %s wvalid_dwe got=%b/%b exp=0/00", name, sram_wtag_o[20], sram_data_we_o); end
        tick();
        hit_way_i = '0;
        #1;
        vec_cnt++; if (done_o !== 1'b1 || done_valid_o !== 2'b00) begin err_cnt++; $display("FAIL %s done got=%b/%b exp=1/00", name, done_o, done_valid_o); end
        tick();
        vec_cnt++; if (miss_ready_o !== 1'b1) begin err_cnt++; $display("FAIL %s ready got=%b exp=1", name, miss_ready_o); end
    endtask

    task automatic test_flush_idle();
        miss_valid_i = 1; flush_i = 1; miss_paddr_i = 32'h0000_4000; miss_mask_i = 2'b11;
        tick();
        miss_valid_i = 0; flush_i = 0;
        #1;
        vec_cnt++; if (dbg_state !== ST_IDLE || bus_req_valid_o !== 1'b0) begin err_cnt++; $display("FAIL flush_idle_block got=%0d/%b exp=%0d/0", dbg_state, bus_req_valid_o, ST_IDLE); end
    endtask

    task automatic test_back_to_back();
        test_cached_miss(32'h2000_0010, 2'b11, 2'b01, 32'h0000_0100, 0, -1, "b2b0");
        test_cached_miss(32'h3000_0010, 2'b11, 2'b10, 32'h0000_0200, 0, -1, "b2b1");
        test_cached_miss(32'h4000_0010, 2'b01, 2'b01, 32'h0000_0300, 0, -1, "b2b2");
    endtask

    initial begin
        test_reset();
        test_cached_miss(32'h1C00_0008, 2'b11, 2'b01, 32'h0000_00A0, 0, -1, "cached");
        test_uncached();
        test_cached_miss(32'h0800_0004, 2'b01, 2'b10, 32'h0000_00E0, 3, -1, "busy");
        test_cached_miss(32'h0900_0000, 2'b11, 2'b01, 32'h0000_00F0, 0, 1, "flush");
        test_flush_idle();
        test_cacheop(CACOP_HIT_INV,  32'h0000_5000, 2'b10, 2'b10, "cop_hit");
        test_cacheop(CACOP_IDX_INV1, 32'h0000_5000, 2'b00, 2'b01, "cop_idx_w0");
        test_cacheop(CACOP_IDX_INV0, 32'h0000_5001, 2'b00, 2'b10, "cop_idx_w1");
        test_cacheop(CACOP_NOP,      32'h0000_5000, 2'b11, 2'b00, "cop_nop");
        test_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
